// File: rtl/lcd_seq_pkg.sv
// lcd_seq_pkg: shared widths, mode indices, state encoding and mode-wrap helper
package lcd_seq_pkg;
  localparam int MODE_W  = 3;
  localparam int PHASE_W = 10;
  typedef enum logic [MODE_W-1:0] {
    MODE_GRAFTAL = 3'd0,
    MODE_HBARS   = 3'd1,
    MODE_VBARS   = 3'd2,
    MODE_GRAY    = 3'd3,
    MODE_CUSTOM  = 3'd4
  } mode_e;
  typedef enum logic [1:0] {WAIT, RUN, PAUSE} state_e;
  function automatic logic [MODE_W-1:0] mode_inc(input logic [MODE_W-1:0] m, input int unsigned n);
    return (m == MODE_W'(n - 1)) ? '0 : m + 1'b1;
  endfunction
endpackage

// File: rtl/lcd_pattern_seq_if.sv
// lcd_pattern_seq_if: frame/request inputs and mode/phase status of the sequencer
interface lcd_pattern_seq_if;
  import lcd_seq_pkg::*;
  logic               frame_start_i;
  logic               next_req_i;
  logic               pause_req_i;
  logic [MODE_W-1:0]  mode_o;
  logic [PHASE_W-1:0] phase_o;
  logic               mode_changed_o;
  logic               paused_o;
  modport master (output frame_start_i, next_req_i, pause_req_i,
                  input  mode_o, phase_o, mode_changed_o, paused_o);
  modport slave  (input  frame_start_i, next_req_i, pause_req_i,
                  output mode_o, phase_o, mode_changed_o, paused_o);
endinterface

// File: rtl/lcd_frame_divider.sv
// lcd_frame_divider: counts enabled frame_start ticks, pulses step on the terminal count
module lcd_frame_divider #(
  parameter int FRAMES_PER_STEP = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic en_i,
  input  logic clr_i,
  output logic step_o
);
  localparam int CW = $clog2(FRAMES_PER_STEP + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign step_o = tick_i && en_i && cnt_q == CW'(FRAMES_PER_STEP - 1);
  always_comb cnt_d = (clr_i || step_o) ? '0 : (tick_i && en_i) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/lcd_pattern_seq.sv
// lcd_pattern_seq: frame-synchronous pattern/phase sequencer for the LCD pattern generator
// Define LCD_SEQ_AUTO_ADVANCE_EN to advance the mode whenever phase wraps.
module lcd_pattern_seq
  import lcd_seq_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 30,
  parameter int PHASE_MAX       = 999,
  parameter int NUM_MODES       = 5
) (
  input logic               clk,
  input logic               rst,
  lcd_pattern_seq_if.slave  bus
);
  state_e             state_q, state_d;
  logic               pend_q, chg_q, paused_q;
  logic [MODE_W-1:0]  mode_q;
  logic [PHASE_W-1:0] phase_q;
  logic               adv, step, wrap;
  // a request on the same frame_start counts as pending, so it wins over the step tick
  assign adv  = bus.frame_start_i && state_q != WAIT && (pend_q || bus.next_req_i);
  assign wrap = phase_q == PHASE_W'(PHASE_MAX);
  always_comb state_d = (state_q == WAIT) ? (bus.frame_start_i ? RUN : WAIT) :
                        bus.pause_req_i ? ((state_q == RUN) ? PAUSE : RUN) : state_q;
  lcd_frame_divider #(.FRAMES_PER_STEP(FRAMES_PER_STEP)) u_div (
    .clk    (clk),
    .rst    (rst),
    .tick_i (bus.frame_start_i),
    .en_i   (state_q == RUN),
    .clr_i  (adv),
    .step_o (step)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= WAIT;
      pend_q   <= 1'b0;
      mode_q   <= MODE_GRAFTAL;
      phase_q  <= '0;
      chg_q    <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      paused_q <= state_d == PAUSE;
      pend_q   <= (pend_q || bus.next_req_i) && !adv;
      chg_q    <= 1'b0;
      if (adv) begin
        mode_q  <= mode_inc(mode_q, NUM_MODES);
        phase_q <= '0;
        chg_q   <= 1'b1;
      end else if (step) begin
        phase_q <= wrap ? '0 : phase_q + 1'b1;
`ifdef LCD_SEQ_AUTO_ADVANCE_EN
        if (wrap) begin
          mode_q <= mode_inc(mode_q, NUM_MODES);
          chg_q  <= 1'b1;
        end
`endif
      end
    end
  assign bus.mode_o         = mode_q;
  assign bus.phase_o        = phase_q;
  assign bus.mode_changed_o = chg_q;
  assign bus.paused_o       = paused_q;
endmodule

// File: doc/lcd_pattern_seq.md
# lcd_pattern_seq

Frame-synchronous sequencer for the LCD pattern datapath: selects which test pattern the pixel generator draws (`mode`) and supplies its animation parameter (`phase`). It counts frames instead of raw clocks, so all changes occur at a frame boundary with no tearing. It sits between the timing generator, which supplies the frame-start pulse, and the pattern generator, and takes single-pulse user requests (next pattern, pause).

## Interface
- `FRAMES_PER_STEP`, 30: frames per phase increment (≥1).
- `PHASE_MAX`, 999: last phase value before wrap (≥1).
- `NUM_MODES`, 5: number of patterns (2..8).
- `clk` in 1: pixel clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse at the first blanking cycle of each frame.
- `next_req` in 1: one-cycle pulse requesting the next pattern.
- `pause_req` in 1: one-cycle pulse toggling pause.
- `mode` out 3: current pattern index, 0..NUM_MODES-1.
- `phase` out 10: animation parameter, 0..PHASE_MAX.
- `mode_changed` out 1: one-cycle pulse when `mode` updates.
- `paused` out 1: high while in PAUSE.

## Operation
- Reset values: `mode`=0, `phase`=0, `mode_changed`=0, `paused`=0. Internal frame count = 0, pending flag = 0, state = WAIT.
- State machine:
  - WAIT: after reset, nothing advances. Go to RUN on the first `frame_start`; that pulse is not counted.
  - RUN ↔ PAUSE: toggled by `pause_req`, effective the next cycle, at any time. Not restricted to frame boundaries.
- `next_req` sets a sticky pending flag in every state. The flag is consumed only on a `frame_start` in RUN or PAUSE.
- On `frame_start` with the pending flag set, or with `next_req` asserted in the same cycle:
  - `mode` ← `mode`+1, wrapping NUM_MODES-1→0.
  - `phase` ← 0; frame count ← 0; flag cleared; `mode_changed` pulses.
  - This has priority over the step tick.
- On `frame_start` in RUN with no pending request:
  - If frame count = FRAMES_PER_STEP-1: frame count ← 0, and `phase` increments, wrapping PHASE_MAX→0.
  - Otherwise frame count increments.
- PAUSE freezes the frame count and `phase`. Pending mode changes still apply.
- `pause_req` and `frame_start` in the same cycle: the `frame_start` is processed under the old state.
- Any `rst` assertion, including mid-frame or with a request pending, returns immediately to the reset values.

## Timing
- All outputs are registered.
- `mode` and `phase` change exactly one cycle after the `frame_start` edge that causes the change, and are otherwise stable for the whole frame.
- `mode_changed` is high for exactly the cycle in which the new `mode` first appears.
- `paused` follows `pause_req` with 1-cycle latency.
- `next_req` pulses while the flag is already pending merge into the single pending request: at most one mode step per frame.

## Configuration
- `LCD_SEQ_AUTO_ADVANCE_EN` defined: when `phase` wraps PHASE_MAX→0 on a step tick, `mode` also advances (with wrap) and `mode_changed` pulses.
- Not defined: `mode` changes only via `next_req`. `phase` wraps and the pattern stays the same.

## Structure
- Package `lcd_seq_pkg`:
  - Mode index constants: MODE_GRAFTAL, MODE_HBARS, MODE_VBARS, MODE_GRAY, MODE_CUSTOM = 0..4.
  - State encoding: WAIT, RUN, PAUSE.
  - Output widths.
- Sub-module `lcd_frame_divider`:
  - Counts `frame_start` pulses with enable and clear inputs.
  - Emits a one-cycle `step` pulse on the terminal count.
- The top level holds the FSM, the pending flag, and the `mode`/`phase` registers.

## Test plan
All scenarios use FRAMES_PER_STEP=2, PHASE_MAX=3, NUM_MODES=3.
- Reset, then 9 `frame_start` pulses → first pulse ignored; `phase` sequence 0,0,1,1,2,2,3,3 → wraps to 0 after the 9th. `mode` stays 0 without the macro; becomes 1 with `mode_changed` pulsing once with the macro.
- `next_req` mid-frame at `mode`=2, `phase`=2 → no change until the next `frame_start`; one cycle later `mode`=0, `phase`=0, `mode_changed`=1 for one cycle.
- `next_req` in the same cycle as a step-tick `frame_start` → `mode` advances, `phase`=0, no phase increment.
- Three `next_req` pulses within one frame → exactly one mode step at the next `frame_start`.
- `pause_req`, then 4 `frame_start` pulses → `phase` is unchanged and `paused`=1. A `next_req` during pause still changes `mode`. A second `pause_req` → counting resumes from the frozen frame count.
- Assert `rst` mid-frame with a request pending → all outputs 0 in the same cycle; no mode change on the following `frame_start` (state WAIT).
